// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and stream constants.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR_ADDR,
      ST_HDR_LEN,
      ST_LOAD,
      ST_RELEASE,
      ST_RUN,
      ST_HALTED,
      ST_ERR
   } state_t;

   // Stream header: word 0 is the base byte address, word 1 the length in words.
   localparam int HDR_IDX_ADDR = 0;
   localparam int HDR_IDX_LEN  = 1;
   localparam int WORD_BYTES   = 4;

endpackage

// File: rtl/prog_loader.sv
// Streams a program image into IMEM/DMEM through word writes while holding the CPU
// in reset, then releases the CPU and waits for it to halt.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int MAX_WORDS = 65536
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wr_data,
   output logic              cpu_rst,
   input  logic              cpu_halt,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       checksum
);

   // Wide enough to hold base + 4*N for any 32-bit N without wrapping.
   localparam int EXT_W = ((ADDR_W > 34) ? ADDR_W : 34) + 1;
   localparam logic [EXT_W-1:0] ADDR_SPAN = EXT_W'(1) << ADDR_W;

   state_t              state_reg;
   logic [ADDR_W-1:0]   ptr_reg;
   logic [31:0]         len_reg;
   logic [31:0]         idx_reg;
   logic                s_ready_reg;
   logic                mem_wr_en_reg;
   logic [ADDR_W-1:0]   mem_addr_reg;
   logic [31:0]         mem_wr_data_reg;
   logic                cpu_rst_reg;
   logic                busy_reg;
   logic                done_reg;
   logic                err_reg;
   logic [31:0]         checksum_reg;

   logic                xfer;
   logic                base_bad;
   logic                len_bad;
   logic [EXT_W-1:0]    img_end;

   assign xfer     = s_valid && s_ready_reg;
   assign base_bad = (s_data[1:0] != 2'b00);

   // In HDR_LEN, ptr_reg still holds the latched base address.
   assign img_end  = EXT_W'(ptr_reg) + (EXT_W'(s_data) << 2);
   assign len_bad  = (s_data == 32'd0) ||
                     ({1'b0, s_data} > 33'(MAX_WORDS)) ||
                     (img_end > ADDR_SPAN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= ST_IDLE;
         ptr_reg         <= '0;
         len_reg         <= '0;
         idx_reg         <= '0;
         s_ready_reg     <= 1'b0;
         mem_wr_en_reg   <= 1'b0;
         mem_addr_reg    <= '0;
         mem_wr_data_reg <= '0;
         cpu_rst_reg     <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         err_reg         <= 1'b0;
         checksum_reg    <= '0;
      end else begin
         mem_wr_en_reg <= 1'b0;
         case (state_reg)
            ST_IDLE, ST_HALTED, ST_ERR: begin
               if (start) begin
                  state_reg    <= ST_HDR_ADDR;
                  busy_reg     <= 1'b1;
                  done_reg     <= 1'b0;
                  err_reg      <= 1'b0;
                  checksum_reg <= '0;
                  cpu_rst_reg  <= 1'b0;
                  s_ready_reg  <= 1'b1;
               end
            end
            ST_HDR_ADDR: begin
               if (xfer) begin
                  ptr_reg <= ADDR_W'(s_data);
                  if (base_bad) begin
                     state_reg   <= ST_ERR;
                     err_reg     <= 1'b1;
                     busy_reg    <= 1'b0;
                     s_ready_reg <= 1'b0;
                  end else begin
                     state_reg <= ST_HDR_LEN;
                  end
               end
            end
            ST_HDR_LEN: begin
               if (xfer) begin
                  if (len_bad) begin
                     state_reg   <= ST_ERR;
                     err_reg     <= 1'b1;
                     busy_reg    <= 1'b0;
                     s_ready_reg <= 1'b0;
                  end else begin
                     len_reg   <= s_data;
                     idx_reg   <= '0;
                     state_reg <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (xfer) begin
                  mem_wr_en_reg   <= 1'b1;
                  mem_addr_reg    <= ptr_reg;
                  mem_wr_data_reg <= s_data;
                  checksum_reg    <= checksum_reg + s_data;
                  ptr_reg         <= ptr_reg + ADDR_W'(WORD_BYTES);
                  idx_reg         <= idx_reg + 32'd1;
                  if (idx_reg == len_reg - 32'd1) begin
                     s_ready_reg <= 1'b0;
                     state_reg   <= ST_RELEASE;
                  end
               end
            end
            ST_RELEASE: begin
               cpu_rst_reg <= 1'b1;
               state_reg   <= ST_RUN;
            end
            ST_RUN: begin
               if (cpu_halt) begin
                  state_reg <= ST_HALTED;
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign s_ready     = s_ready_reg;
   assign mem_wr_en   = mem_wr_en_reg;
   assign mem_addr    = mem_addr_reg;
   assign mem_wr_data = mem_wr_data_reg;
   assign cpu_rst     = cpu_rst_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign err         = err_reg;
   assign checksum    = checksum_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: normal loads, stream gaps, header faults,
// halt handling and asynchronous reset in the middle of a load.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        cpu_halt = 1'b0;
   logic        s_ready;
   logic        mem_wr_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic        cpu_rst;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] checksum;

   prog_loader #(.ADDR_W(32), .MAX_WORDS(65536)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .mem_wr_en   (mem_wr_en),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .cpu_rst     (cpu_rst),
      .cpu_halt    (cpu_halt),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .checksum    (checksum)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   int          hs_q[$];
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          wr_cyc_q[$];
   int          rise_cyc = -1;
   logic        cpu_rst_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Handshake cycle is the count before the edge; the write shows up with count+1.
   always @(posedge clk) begin
      if (rst && s_valid && s_ready) hs_q.push_back(cyc);
   end

   always @(negedge clk) begin
      if (mem_wr_en) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wr_data);
         wr_cyc_q.push_back(cyc);
      end
      if (cpu_rst && !cpu_rst_prev) rise_cyc <= cyc;
      cpu_rst_prev <= cpu_rst;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] w);
      int n = 0;
      s_data  = w;
      s_valid = 1'b1;
      while (!s_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) chk("send_timeout_s_ready", s_ready, 1);
      else @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic halt_cpu(input string tag);
      cpu_halt = 1'b1;
      tick(1);
      cpu_halt = 1'b0;
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_cpu_rst"}, cpu_rst, 1);
   endtask

   // Loads an image and checks addresses, data, write latency, checksum and release timing.
   task automatic load_and_check(input string tag, input logic [31:0] base,
                                 input logic [31:0] img[$], input int gap);
      int w0;
      int h0;
      int n;
      logic [31:0] sum;
      w0  = wr_addr_q.size();
      h0  = hs_q.size();
      n   = img.size();
      sum = '0;
      pulse_start();
      chk({tag, "_busy_on_start"}, busy, 1);
      chk({tag, "_err_cleared"}, err, 0);
      chk({tag, "_cpu_held"}, cpu_rst, 0);
      chk({tag, "_s_ready"}, s_ready, 1);
      chk({tag, "_cksum_clr"}, checksum, 0);
      send(base);
      send(32'(n));
      for (int i = 0; i < n; i++) begin
         if (i > 0 && gap > 0) begin
            // start and cpu_halt must both be ignored mid-load
            cpu_halt = 1'b1;
            start    = 1'b1;
            tick(1);
            cpu_halt = 1'b0;
            start    = 1'b0;
            tick(gap - 1);
         end
         sum = sum + img[i];
         send(img[i]);
      end
      tick(3);
      chk({tag, "_num_writes"}, wr_addr_q.size() - w0, n);
      if (wr_addr_q.size() - w0 == n && hs_q.size() - h0 == n + 2) begin
         for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wr_addr_q[w0 + i], base + 32'(4 * i));
            chk($sformatf("%s_data%0d", tag, i), wr_data_q[w0 + i], img[i]);
            chk($sformatf("%s_lat%0d", tag, i), wr_cyc_q[w0 + i] - hs_q[h0 + 2 + i], 1);
         end
         if (gap == 0) chk({tag, "_back_to_back"}, wr_cyc_q[w0 + n - 1] - wr_cyc_q[w0], n - 1);
         chk({tag, "_release_cyc"}, rise_cyc, hs_q[h0 + n + 1] + 2);
      end else begin
         chk({tag, "_handshakes"}, hs_q.size() - h0, n + 2);
      end
      chk({tag, "_checksum"}, checksum, sum);
      chk({tag, "_cpu_run"}, cpu_rst, 1);
      chk({tag, "_busy_run"}, busy, 1);
      chk({tag, "_done_run"}, done, 0);
   endtask

   task automatic expect_err(input string tag, input int w0);
      chk({tag, "_err"}, err, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_s_ready"}, s_ready, 0);
      chk({tag, "_cpu_rst"}, cpu_rst, 0);
      s_valid = 1'b1;
      s_data  = 32'h0000_0040;
      tick(2);
      s_valid = 1'b0;
      chk({tag, "_no_write"}, wr_addr_q.size(), w0);
      chk({tag, "_err_sticky"}, err, 1);
   endtask

   initial begin
      logic [31:0] img[$];
      int h0;
      int w0;

      tick(2);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_wr_en", mem_wr_en, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wr_data, 0);
      chk("rst_cpu_rst", cpu_rst, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_checksum", checksum, 0);
      rst = 1'b1;
      tick(2);

      img = '{32'h0000_0013, 32'h0010_0093, 32'h0000_0073};
      load_and_check("normal", 32'h0000_0000, img, 0);
      chk("normal_cksum_const", checksum, 32'h0010_0119);
      halt_cpu("halt1");
      tick(2);
      chk("halted_cpu_frozen", cpu_rst, 1);

      load_and_check("gaps", 32'h0000_0000, img, 2);
      halt_cpu("halt2");

      w0 = wr_addr_q.size();
      pulse_start();
      send(32'h0000_0102);
      expect_err("misaligned", w0);

      img = '{32'hDEAD_BEEF};
      load_and_check("after_err", 32'h0000_0040, img, 0);
      halt_cpu("halt3");

      w0 = wr_addr_q.size();
      pulse_start();
      send(32'h0000_0000);
      send(32'd0);
      expect_err("len_zero", w0);

      w0 = wr_addr_q.size();
      pulse_start();
      send(32'hFFFF_FFF8);
      send(32'd3);
      expect_err("len_overflow", w0);

      img = '{32'h1111_1111, 32'h2222_2222};
      load_and_check("top_of_mem", 32'hFFFF_FFF8, img, 0);
      halt_cpu("halt4");

      pulse_start();
      send(32'h0000_0100);
      send(32'd5);
      send(32'hA000_0001);
      send(32'hA000_0002);
      rst = 1'b0;
      #1;
      chk("abort_s_ready", s_ready, 0);
      chk("abort_wr_en", mem_wr_en, 0);
      chk("abort_addr", mem_addr, 0);
      chk("abort_wdata", mem_wr_data, 0);
      chk("abort_cpu_rst", cpu_rst, 0);
      chk("abort_busy", busy, 0);
      chk("abort_checksum", checksum, 0);
      tick(2);
      rst = 1'b1;
      tick(1);
      h0 = hs_q.size();
      w0 = wr_addr_q.size();
      s_valid = 1'b1;
      s_data  = 32'hA000_0003;
      tick(3);
      s_valid = 1'b0;
      chk("idle_no_handshake", hs_q.size(), h0);
      chk("idle_no_write", wr_addr_q.size(), w0);
      chk("idle_busy", busy, 0);
      pulse_start();
      chk("restart_s_ready", s_ready, 1);
      chk("restart_busy", busy, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
      $fatal(1);
   end

endmodule
